// File: rtl/dbus_sram_resp_pkg.sv
// common: shared data-bus request/response types, responder state and window check
package common;
   typedef enum logic [2:0] {MSIZE1, MSIZE2, MSIZE4, MSIZE8} msize_t;
   typedef struct packed {
      logic        valid;
      logic [63:0] addr;
      msize_t      size;
      logic [7:0]  strobe;
      logic [63:0] data;
   } dbus_req_t;
   typedef struct packed {
      logic        addr_ok;
      logic        data_ok;
      logic [63:0] data;
   } dbus_resp_t;
   typedef enum logic [1:0] {IDLE, WAIT, DONE} resp_state_t;
   function automatic logic in_window(input logic [63:0] addr, input logic [63:0] base, input int unsigned depth);
      return ((addr - base) >> 3) < 64'(depth);
   endfunction
endpackage

// File: rtl/dbus_sram_resp_sram_bank.sv
// sram_bank: DEPTH_WORDS x 64-bit single-port store, async read, sync byte-enabled write
// ports: clk, we (write enable), be (byte enables), idx (word index), wdata, rdata
module sram_bank #(
   parameter int unsigned DEPTH_WORDS = 1024,
   localparam int AW = $clog2(DEPTH_WORDS)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [7:0]    be,
   input  logic [AW-1:0] idx,
   input  logic [63:0]   wdata,
   output logic [63:0]   rdata
);
   logic [63:0] mem [DEPTH_WORDS];
   assign rdata = mem[idx];
   always_ff @(posedge clk)
      if (we)
         for (int i = 0; i < 8; i++)
            if (be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
endmodule

// File: rtl/dbus_sram_resp.sv
// dbus_sram_resp: fixed-latency data-bus responder backed by a byte-writable SRAM
// ports: clk, reset (sync, active-high), dreq (request in), dresp (addr_ok/data_ok/data out), err (sticky out-of-range)
module dbus_sram_resp
   import common::*;
#(
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter int unsigned LATENCY     = 2,
   parameter logic [63:0] BASE_ADDR   = 64'h8000_0000
) (
   input  logic       clk,
   input  logic       reset,
   input  dbus_req_t  dreq,
   output dbus_resp_t dresp,
   output logic       err
);
   localparam int AW = $clog2(DEPTH_WORDS);
   resp_state_t state, state_nx;
   logic [3:0]  cnt, cnt_nx;
   logic [63:0] addr_q, data_q, rdata;
   logic [7:0]  strobe_q;
   msize_t      size_q_unused;
   logic        hit_q, hit_in, accept;
   assign hit_in = in_window(dreq.addr, BASE_ADDR, DEPTH_WORDS);
   assign accept = state == IDLE && dreq.valid && !reset;
   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      case (state)
         IDLE: if (dreq.valid) begin
            state_nx = LATENCY == 1 ? DONE : WAIT;
            cnt_nx   = 4'(LATENCY - 1);
         end
         WAIT: begin
            cnt_nx   = cnt - 4'd1;
            state_nx = cnt == 4'd1 ? DONE : WAIT;
         end
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= '0;
         err   <= 1'b0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
         err   <= err | (accept && !hit_in);
      end
      if (accept) begin
         addr_q        <= dreq.addr;
         data_q        <= dreq.data;
         strobe_q      <= dreq.strobe;
         size_q_unused <= dreq.size;
         hit_q         <= hit_in;
      end
   end
   // Commit only in DONE, in range, and never in a reset cycle so an aborted write is lost.
   sram_bank #(.DEPTH_WORDS(DEPTH_WORDS)) u_bank (
      .clk,
      .we   (state == DONE && hit_q && !reset),
      .be   (strobe_q),
      .idx  (AW'((addr_q - BASE_ADDR) >> 3)),
      .wdata(data_q),
      .rdata
   );
   assign dresp = '{addr_ok: accept, data_ok: state == DONE, data: (state == DONE && hit_q) ? rdata : 64'h0};
endmodule

// File: tb/tb_dbus_sram_resp.sv
// tb_dbus_sram_resp: randomized scoreboard bench over three latencies (1, 2, 3)
module tb_dbus_sram_resp;
   import common::*;
   localparam int DW = 32;
   localparam logic [63:0] BASE = 64'h8000_0000;
   typedef struct {logic [63:0] data; int due; logic err;} exp_t;
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic       reset [3];
   dbus_req_t  dreq  [3];
   dbus_resp_t dresp [3];
   logic       err   [3];
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;
   int total = 0, passed = 0;
   exp_t q [3][$];
   logic [63:0] mem_m [3][DW];
   logic err_m [3];
   dbus_sram_resp #(.DEPTH_WORDS(DW), .LATENCY(1), .BASE_ADDR(BASE)) u_l1 (.clk, .reset(reset[0]), .dreq(dreq[0]), .dresp(dresp[0]), .err(err[0]));
   dbus_sram_resp #(.DEPTH_WORDS(DW), .LATENCY(2), .BASE_ADDR(BASE)) u_l2 (.clk, .reset(reset[1]), .dreq(dreq[1]), .dresp(dresp[1]), .err(err[1]));
   dbus_sram_resp #(.DEPTH_WORDS(DW), .LATENCY(3), .BASE_ADDR(BASE)) u_l3 (.clk, .reset(reset[2]), .dreq(dreq[2]), .dresp(dresp[2]), .err(err[2]));
   function automatic void check(string name, logic [63:0] act, logic [63:0] want);
      total++;
      if (act === want) passed++;
      else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, want, cyc);
   endfunction
   function automatic logic [63:0] rnd64();
      return {$urandom, $urandom};
   endfunction
   function automatic logic [63:0] waddr(int i);
      return BASE + 64'(i) * 64'd8 + 64'($urandom_range(0, 7));
   endfunction
   always @(negedge clk) begin
      for (int k = 0; k < 3; k++) begin
         if (dresp[k].data_ok) begin
            if (q[k].size() == 0) check($sformatf("spurious_data_ok_u%0d", k), 64'd1, 64'd0);
            else begin
               exp_t e;
               e = q[k].pop_front();
               check($sformatf("data_u%0d", k), dresp[k].data, e.data);
               check($sformatf("latency_u%0d", k), 64'(cyc), 64'(e.due));
               check($sformatf("err_u%0d", k), 64'(err[k]), 64'(e.err));
            end
         end else begin
            check($sformatf("idle_data_zero_u%0d", k), dresp[k].data, 64'h0);
            if (q[k].size() != 0 && cyc > q[k][0].due) begin
               check($sformatf("missing_data_ok_u%0d", k), 64'd0, 64'd1);
               void'(q[k].pop_front());
            end
         end
      end
   end
   task automatic issue(int k, logic [63:0] a, logic [7:0] s, logic [63:0] d, bit abort);
      exp_t e;
      int w, wi;
      logic [63:0] idx;
      @(negedge clk);
      dreq[k].valid  = 1'b1;
      dreq[k].addr   = a;
      dreq[k].size   = msize_t'($urandom_range(0, 3));
      dreq[k].strobe = s;
      dreq[k].data   = d;
      #1;
      w = 0;
      while (!dresp[k].addr_ok && w < 20) begin
         @(negedge clk);
         #1;
         w++;
      end
      if (!dresp[k].addr_ok) begin
         check($sformatf("addr_ok_timeout_u%0d", k), 64'd0, 64'd1);
         dreq[k].valid = 1'b0;
         return;
      end
      if (abort) begin
         @(negedge clk);
         reset[k] = 1'b1;
         @(negedge clk);
         reset[k] = 1'b0;
         dreq[k].valid = 1'b0;
         err_m[k] = 1'b0;
         #1;
         check($sformatf("abort_data_ok_u%0d", k), 64'(dresp[k].data_ok), 64'd0);
         check($sformatf("abort_addr_ok_u%0d", k), 64'(dresp[k].addr_ok), 64'd0);
         check($sformatf("abort_err_u%0d", k), 64'(err[k]), 64'd0);
         return;
      end
      idx = (a - BASE) >> 3;
      if (idx >= 64'(DW)) err_m[k] = 1'b1;
      e.due = cyc + k + 1;
      e.err = err_m[k];
      e.data = 64'h0;
      if (idx < 64'(DW)) begin
         wi = int'(idx);
         e.data = mem_m[k][wi];
         for (int i = 0; i < 8; i++)
            if (s[i]) mem_m[k][wi][8*i +: 8] = d[8*i +: 8];
      end
      q[k].push_back(e);
      // Scramble the bus while the request is in flight; valid stays high so back-to-back holds.
      repeat (k + 1) begin
         @(negedge clk);
         dreq[k].addr   = rnd64();
         dreq[k].data   = rnd64();
         dreq[k].strobe = 8'($urandom);
      end
   endtask
   task automatic idle(int k, int n);
      @(negedge clk);
      dreq[k].valid = 1'b0;
      repeat (n - 1) @(negedge clk);
   endtask
   initial begin
      logic [63:0] a;
      for (int k = 0; k < 3; k++) begin
         reset[k] = 1'b1;
         err_m[k] = 1'b0;
         dreq[k] = '0;
         dreq[k].valid = 1'b1;
         dreq[k].addr = BASE;
      end
      repeat (3) @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         reset[k] = 1'b0;
         dreq[k].valid = 1'b0;
      end
      #1;
      for (int k = 0; k < 3; k++) begin
         check($sformatf("rst_addr_ok_u%0d", k), 64'(dresp[k].addr_ok), 64'd0);
         check($sformatf("rst_data_ok_u%0d", k), 64'(dresp[k].data_ok), 64'd0);
         check($sformatf("rst_data_u%0d", k), dresp[k].data, 64'h0);
         check($sformatf("rst_err_u%0d", k), 64'(err[k]), 64'd0);
      end
      for (int k = 0; k < 3; k++) begin
         for (int i = 0; i < DW; i++) issue(k, waddr(i), 8'hFF, rnd64(), 1'b0);
         idle(k, 2);
      end
      issue(1, 64'h8000_0010, 8'hFF, 64'h1122334455667788, 1'b0);
      issue(1, 64'h8000_0010, 8'h00, rnd64(), 1'b0);
      issue(1, 64'h8000_0010, 8'h0F, 64'hAAAAAAAA_BBBBBBBB, 1'b0);
      issue(1, 64'h8000_0010, 8'h00, rnd64(), 1'b0);
      idle(1, 2);
      issue(1, BASE + 64'd8 * 64'(DW), 8'h00, rnd64(), 1'b0);
      issue(1, BASE - 64'd8, 8'hFF, rnd64(), 1'b0);
      for (int i = 0; i < 3; i++) issue(1, waddr(DW - 1 - i), 8'h00, rnd64(), 1'b0);
      issue(1, 64'h8000_0010, 8'h00, rnd64(), 1'b0);
      idle(1, 2);
      issue(2, waddr(5), 8'hFF, rnd64(), 1'b1);
      issue(2, waddr(5), 8'h00, rnd64(), 1'b0);
      idle(2, 2);
      for (int i = 0; i < 4; i++) issue(0, waddr(i), 8'h00, rnd64(), 1'b0);
      idle(0, 2);
      for (int k = 0; k < 3; k++) begin
         repeat (40) begin
            a = $urandom_range(0, 7) == 0 ? rnd64() : waddr($urandom_range(0, DW - 1));
            issue(k, a, $urandom_range(0, 1) == 1 ? 8'($urandom) : 8'h00, rnd64(), 1'b0);
         end
         idle(k, 2);
      end
      repeat (6) @(negedge clk);
      for (int k = 0; k < 3; k++) check($sformatf("undelivered_u%0d", k), 64'(q[k].size()), 64'd0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
